// File: rtl/rbm_pkg.sv
// Shared definitions for the RBM vote controller.
//   state_e  : FSM state encoding (also exported on the debug state port)
//   clog2    : constant-friendly ceiling log2, never returns less than 1
//   sat_inc  : saturating increment on a 32-bit container; callers zero-extend
//              their narrower counter in and truncate the result back out
package rbm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_WAIT    = 3'd2,
    ST_EVAL    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int SAT_W = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/rbm_top2.sv
// Combinational search for the largest and second-largest vote count.
//   votes        : OUTPUT_DIM packed counters, class i at [i*COUNT_W +: COUNT_W]
//   top_count    : largest count
//   second_count : largest count among the other classes (equals top_count on a tie)
//   top_idx      : lowest index holding top_count
module rbm_top2
  import rbm_pkg::*;
#(
  parameter int OUTPUT_DIM = 10,
  parameter int COUNT_W    = 12,
  parameter int IDX_W      = clog2(OUTPUT_DIM)
) (
  input  logic [OUTPUT_DIM*COUNT_W-1:0] votes,
  output logic [COUNT_W-1:0]            top_count,
  output logic [COUNT_W-1:0]            second_count,
  output logic [IDX_W-1:0]              top_idx
);

  logic [COUNT_W-1:0] cur;

  always_comb begin
    top_count    = votes[0 +: COUNT_W];
    second_count = '0;
    top_idx      = '0;
    cur          = '0;
    for (int i = 1; i < OUTPUT_DIM; i++) begin
      cur = votes[i*COUNT_W +: COUNT_W];
      // Strict compare keeps the earlier index on ties; the tied value then
      // lands in second_count so the lead becomes zero.
      if (cur > top_count) begin
        second_count = top_count;
        top_count    = cur;
        top_idx      = IDX_W'(i);
      end else if (cur > second_count) begin
        second_count = cur;
      end
    end
  end

endmodule

// File: rtl/rbm_vote_controller.sv
// Iterative vote controller for a stochastic RBM classifier.
// A run restarts the layer chain, collects one sample per iteration into
// per-class saturating vote counters, and stops on the iteration limit or
// when the leading class is ahead of the runner-up by the requested margin.
//   in_valid/in_ready   : run request; accepted when both are high (IDLE only)
//   iter_num, margin    : run limits, captured on acceptance
//   layer_restart       : one-cycle pulse per iteration to the layer chain
//   layer_done, sample  : layer result, consumed only while waiting for it
//   votes, winner, iter_count, early_stop : result, held until the next run
//   out_valid/out_ready : result handshake; transfer when both are high
//   state_dbg           : current FSM state
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid never depends on ready, and the producer holds its
// payload stable while valid is high and ready is low.
module rbm_vote_controller
  import rbm_pkg::*;
#(
  parameter int OUTPUT_DIM = 10,
  parameter int COUNT_W    = 12,
  parameter int ITER_W     = 10,
  parameter int IDX_W      = clog2(OUTPUT_DIM)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ITER_W-1:0]             iter_num,
  input  logic [COUNT_W-1:0]            margin,
  output logic                          layer_restart,
  input  logic                          layer_done,
  input  logic [OUTPUT_DIM-1:0]         sample,
  output logic [OUTPUT_DIM*COUNT_W-1:0] votes,
  output logic [IDX_W-1:0]              winner,
  output logic [ITER_W-1:0]             iter_count,
  output logic                          early_stop,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2:0]                    state_dbg
);

  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'((64'd1 << COUNT_W) - 64'd1);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   votes_q [OUTPUT_DIM];
  logic [COUNT_W-1:0]   votes_d [OUTPUT_DIM];
  logic [ITER_W-1:0]    iter_count_q, iter_count_d;
  logic [ITER_W-1:0]    iter_max_q, iter_max_d;
  logic [COUNT_W-1:0]   margin_q, margin_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic                 early_stop_q, early_stop_d;

  logic [OUTPUT_DIM*COUNT_W-1:0] votes_flat;
  logic [COUNT_W-1:0]   top_count, second_count, lead;
  logic [IDX_W-1:0]     top_idx;
  logic                 limit_hit, margin_hit;

  always_comb begin
    votes_flat = '0;
    for (int i = 0; i < OUTPUT_DIM; i++) begin
      votes_flat[i*COUNT_W +: COUNT_W] = votes_q[i];
    end
  end

  rbm_top2 #(
    .OUTPUT_DIM (OUTPUT_DIM),
    .COUNT_W    (COUNT_W),
    .IDX_W      (IDX_W)
  ) u_top2 (
    .votes        (votes_flat),
    .top_count    (top_count),
    .second_count (second_count),
    .top_idx      (top_idx)
  );

  // top_count >= second_count always, so the lead cannot underflow.
  assign lead       = top_count - second_count;
  assign limit_hit  = (iter_count_q == iter_max_q);
  assign margin_hit = (margin_q != '0) && (lead >= margin_q);

  always_comb begin
    state_d      = state_q;
    votes_d      = votes_q;
    iter_count_d = iter_count_q;
    iter_max_d   = iter_max_q;
    margin_d     = margin_q;
    winner_d     = winner_q;
    early_stop_d = early_stop_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          iter_max_d   = iter_num;
          margin_d     = margin;
          iter_count_d = '0;
          winner_d     = '0;
          early_stop_d = 1'b0;
          for (int i = 0; i < OUTPUT_DIM; i++) votes_d[i] = '0;
          state_d = (iter_num == '0) ? ST_DONE : ST_RESTART;
        end
      end
      ST_RESTART: state_d = ST_WAIT;
      ST_WAIT: begin
        if (layer_done) begin
          for (int i = 0; i < OUTPUT_DIM; i++) begin
            if (sample[i]) votes_d[i] = COUNT_W'(sat_inc(SAT_W'(votes_q[i]), CNT_MAX));
          end
          iter_count_d = iter_count_q + 1'b1;
          state_d      = ST_EVAL;
        end
      end
      ST_EVAL: begin
        winner_d = top_idx;
        // The iteration limit wins over the margin: early_stop only when the
        // limit has not also been reached.
        if (limit_hit) begin
          state_d = ST_DONE;
        end else if (margin_hit) begin
          early_stop_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          state_d = ST_RESTART;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      iter_count_q <= '0;
      iter_max_q   <= '0;
      margin_q     <= '0;
      winner_q     <= '0;
      early_stop_q <= 1'b0;
      for (int i = 0; i < OUTPUT_DIM; i++) votes_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      iter_count_q <= iter_count_d;
      iter_max_q   <= iter_max_d;
      margin_q     <= margin_d;
      winner_q     <= winner_d;
      early_stop_q <= early_stop_d;
      for (int i = 0; i < OUTPUT_DIM; i++) votes_q[i] <= votes_d[i];
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign layer_restart = (state_q == ST_RESTART);
  assign out_valid     = (state_q == ST_DONE);
  assign votes         = votes_flat;
  assign winner        = winner_q;
  assign iter_count    = iter_count_q;
  assign early_stop    = early_stop_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_rbm_vote_controller.sv
// Bench for rbm_vote_controller with 3-bit vote counters so saturation is
// reachable. Each run's expected result comes from a reference model and is
// queued when the request is driven, then popped when out_valid appears.
module tb_rbm_vote_controller;

  localparam int OD      = 10;
  localparam int CW      = 3;
  localparam int IW      = 10;
  localparam int XW      = 4;
  localparam int SAT_MAX = (1 << CW) - 1;
  localparam int EXP_W   = OD*CW + XW + IW + 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [IW-1:0]  iter_num = '0;
  logic [CW-1:0]  margin = '0;
  logic           layer_restart;
  logic           layer_done = 1'b0;
  logic [OD-1:0]  sample = '0;
  logic [OD*CW-1:0] votes;
  logic [XW-1:0]  winner;
  logic [IW-1:0]  iter_count;
  logic           early_stop;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2:0]     state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [OD-1:0]    smp_tab [0:31];

  rbm_vote_controller #(
    .OUTPUT_DIM (OD),
    .COUNT_W    (CW),
    .ITER_W     (IW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .iter_num      (iter_num),
    .margin        (margin),
    .layer_restart (layer_restart),
    .layer_done    (layer_done),
    .sample        (sample),
    .votes         (votes),
    .winner        (winner),
    .iter_count    (iter_count),
    .early_stop    (early_stop),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .state_dbg     (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic fill_smp(input logic [OD-1:0] v);
    for (int i = 0; i < 32; i++) smp_tab[i] = v;
  endtask

  // Reference model: replay the sample table and stop as the run should.
  task automatic model_push(input int n_iter, input int mrg);
    int cnt [OD];
    int iters, early, top, second, win;
    logic [OD*CW-1:0] v;
    iters = 0; early = 0; win = 0;
    for (int i = 0; i < OD; i++) cnt[i] = 0;
    for (int k = 0; k < n_iter; k++) begin
      for (int i = 0; i < OD; i++)
        if (smp_tab[k][i] && cnt[i] < SAT_MAX) cnt[i]++;
      iters++;
      top = 0;
      for (int i = 0; i < OD; i++) if (cnt[i] > top) top = cnt[i];
      win = 0;
      for (int i = OD-1; i >= 0; i--) if (cnt[i] == top) win = i;
      second = 0;
      for (int i = 0; i < OD; i++) if (i != win && cnt[i] > second) second = cnt[i];
      if (iters == n_iter) break;
      if (mrg != 0 && (top - second) >= mrg) begin early = 1; break; end
    end
    v = '0;
    for (int i = 0; i < OD; i++) v[i*CW +: CW] = CW'(cnt[i]);
    exp_q.push_back({v, XW'(win), IW'(iters), 1'(early)});
  endtask

  // One run: request, serve restarts with a fixed layer latency, then check.
  // noise scrambles request inputs and injects layer_done outside WAIT.
  // abort_at >= 0 asserts reset in WAIT once that many iterations are done.
  task automatic run_job(input int n_iter, input int mrg, input int lat,
                         input bit noise, input int hold, input int abort_at);
    int cyc, restarts, pend, k, budget, iters;
    bit done_ok;
    logic [EXP_W-1:0] e;
    budget = 200;
    while (!in_ready && budget > 0) begin @(negedge clock); budget--; end
    check_eq("start_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    iter_num = IW'(n_iter);
    margin   = CW'(mrg);
    if (abort_at < 0) model_push(n_iter, mrg);
    @(posedge clock);
    cyc = 0; restarts = 0; pend = 0; k = 0; budget = 2000; done_ok = 1'b0;
    while (budget > 0) begin
      @(negedge clock);
      budget--; cyc++;
      if (out_valid) begin done_ok = 1'b1; break; end
      layer_done = 1'b0;
      sample     = '0;
      in_valid   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      iter_num   = IW'($urandom);
      margin     = CW'($urandom);
      if (layer_restart) begin
        restarts++;
        pend = lat;
        if (noise) begin layer_done = 1'b1; sample = OD'($urandom); end
      end else if (pend > 1) begin
        pend--;
      end else if (pend == 1) begin
        pend = 0;
        if (k == abort_at) begin
          in_valid = 1'b0;
          check_eq("abort_iter", 64'(iter_count), 64'(k));
          reset = 1'b1;
          #1;
          check_eq("rst_votes", 64'(votes), 64'd0);
          check_eq("rst_winner", 64'(winner), 64'd0);
          check_eq("rst_iter", 64'(iter_count), 64'd0);
          check_eq("rst_early", 64'(early_stop), 64'd0);
          check_eq("rst_out_valid", 64'(out_valid), 64'd0);
          check_eq("rst_restart", 64'(layer_restart), 64'd0);
          @(negedge clock);
          reset = 1'b0;
          @(negedge clock);
          check_eq("rst_in_ready", 64'(in_ready), 64'd1);
          check_eq("rst_out_valid2", 64'(out_valid), 64'd0);
          return;
        end
        layer_done = 1'b1;
        sample     = smp_tab[k];
        k++;
      end else if (noise) begin
        layer_done = 1'b1;
        sample     = OD'($urandom);
      end
    end
    in_valid = 1'b0; layer_done = 1'b0; sample = '0;
    check_eq("done_seen", 64'(done_ok), 64'd1);
    e = exp_q.pop_front();
    iters = int'(e[1 +: IW]);
    check_eq("votes", 64'(votes), 64'(e[EXP_W-1 -: OD*CW]));
    check_eq("winner", 64'(winner), 64'(e[IW+1 +: XW]));
    check_eq("iter_count", 64'(iter_count), 64'(e[1 +: IW]));
    check_eq("early_stop", 64'(early_stop), 64'(e[0]));
    check_eq("restarts", 64'(restarts), 64'(iters));
    check_eq("latency", 64'(cyc), 64'(iters*(lat+2)+1));
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_winner", 64'(winner), 64'(e[IW+1 +: XW]));
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check_eq("ack_in_ready", 64'(in_ready), 64'd1);
    check_eq("ack_out_valid", 64'(out_valid), 64'd0);
    check_eq("ack_votes_held", 64'(votes), 64'(e[EXP_W-1 -: OD*CW]));
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_eq("reset_in_ready", 64'(in_ready), 64'd1);
    check_eq("reset_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("init_votes", 64'(votes), 64'd0);
    check_eq("init_winner", 64'(winner), 64'd0);
    check_eq("init_iter", 64'(iter_count), 64'd0);
    check_eq("init_early", 64'(early_stop), 64'd0);
    check_eq("init_restart", 64'(layer_restart), 64'd0);
    check_eq("init_in_ready", 64'(in_ready), 64'd1);

    fill_smp(10'h001); smp_tab[1] = 10'h003;
    run_job(3, 0, 1, 1'b0, 0, -1);
    fill_smp(10'h004);
    run_job(30, 4, 2, 1'b1, 0, -1);
    fill_smp(10'h006);
    run_job(2, 0, 1, 1'b1, 0, -1);
    fill_smp(10'h001);
    run_job(10, 0, 3, 1'b0, 0, -1);
    run_job(0, 3, 1, 1'b0, 0, -1);
    fill_smp(10'h004);
    run_job(4, 4, 1, 1'b0, 0, -1);
    fill_smp(10'h002);
    run_job(30, 0, 1, 1'b0, 0, 2);
    fill_smp(10'h001); smp_tab[1] = 10'h003;
    run_job(3, 0, 2, 1'b1, 5, -1);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) smp_tab[i] = OD'($urandom);
      run_job($urandom_range(1, 12), $urandom_range(0, 3), $urandom_range(1, 3),
              1'b1, $urandom_range(0, 2), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rbm_vote_controller.md
RBM_VOTE_CONTROLLER -- requirements
Module: rbm_vote_controller

Interface
REQ-001 The block SHALL have parameter OUTPUT_DIM, default 10, number of output classes.
REQ-002 The block SHALL have parameter COUNT_W, default 12, vote counter width per class.
REQ-003 The block SHALL have parameter ITER_W, default 10, iteration counter width.
REQ-004 The block SHALL have parameter IDX_W, default clog2(OUTPUT_DIM), winner index width.
REQ-005 The block SHALL have port clock, input, 1, rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-007 The block SHALL have port in_valid, input, 1, request to start a classification run.
REQ-008 The block SHALL have port in_ready, output, 1, high only in IDLE.
REQ-009 The block SHALL have port iter_num, input, ITER_W, maximum iterations; sampled on the accepted request.
REQ-010 The block SHALL have port margin, input, COUNT_W, early-stop lead margin; 0 disables early stop; sampled on the accepted request.
REQ-011 The block SHALL have port layer_restart, output, 1, one-cycle restart pulse to the RBM layer chain.
REQ-012 The block SHALL have port layer_done, input, 1, layer chain has a valid sample.
REQ-013 The block SHALL have port sample, input, OUTPUT_DIM, one stochastic output bit per class.
REQ-014 The block SHALL have port votes, output, OUTPUT_DIM*COUNT_W, vote counters, class i at bits [i*COUNT_W +: COUNT_W].
REQ-015 The block SHALL have port winner, output, IDX_W, class index with the most votes.
REQ-016 The block SHALL have port iter_count, output, ITER_W, number of completed iterations.
REQ-017 The block SHALL have port early_stop, output, 1, run ended on the margin condition.
REQ-018 The block SHALL have port out_valid, output, 1, result valid.
REQ-019 The block SHALL have port out_ready, input, 1, consumer accepts the result.

Function
REQ-020 The FSM SHALL have the states IDLE, RESTART, WAIT, EVAL and DONE.
REQ-021 In IDLE, in_valid=1 SHALL latch iter_num and margin, clear votes, iter_count and early_stop, and go to RESTART; if iter_num=0 it SHALL go to DONE with zero votes and winner=0.
REQ-022 In RESTART, layer_restart SHALL be 1 for exactly that cycle, then the FSM SHALL go to WAIT.
REQ-023 In WAIT, layer_done=1 SHALL increment votes[i] for every i with sample[i]=1, increment iter_count, and go to EVAL.
REQ-024 Vote counters SHALL saturate at 2^COUNT_W-1 and SHALL NOT wrap.
REQ-025 layer_done and sample SHALL be ignored in every state except WAIT.
REQ-026 EVAL SHALL go to DONE when iter_count equals the latched iter_num, or when margin is nonzero and (top count − second count) >= margin, setting early_stop=1; otherwise it SHALL go to RESTART.
REQ-027 When both EVAL conditions hold in the same cycle, early_stop SHALL be 0, so that the iteration limit takes precedence.
REQ-028 winner SHALL be the index of the highest count, with the lowest index winning ties; it SHALL be registered in EVAL and held stable.
REQ-029 In DONE, out_valid=1 SHALL hold until out_ready=1, then the FSM SHALL go to IDLE; votes, winner, iter_count and early_stop SHALL hold until the next accepted request.
REQ-030 Each iteration SHALL take 1 RESTART cycle, plus the layer latency in WAIT, plus 1 EVAL cycle; out_valid SHALL rise 1 cycle after the final EVAL.
REQ-031 The latched iter_num and margin SHALL NOT change mid-run regardless of input activity.

Reset
REQ-032 Asserting reset at any time, including mid-run, SHALL force IDLE, clear all counters, set winner=0, early_stop=0, out_valid=0 and layer_restart=0, and set in_ready=1 after deassertion.

Structure
REQ-033 A shared package rbm_pkg SHALL hold the FSM state encoding, a clog2 function and the saturating-increment helper.
REQ-034 A combinational sub-module rbm_top2 SHALL find the top and second vote counts and the top index across OUTPUT_DIM counters.

Verification
REQ-035 The bench SHALL cover: iter_num=3, margin=0, samples 0x001, 0x003, 0x001 -> votes[0]=3, votes[1]=1, winner=0, iter_count=3, early_stop=0.
REQ-036 The bench SHALL cover: iter_num=30, margin=4, sample 0x004 every iteration -> DONE after 4 iterations, winner=2, early_stop=1.
REQ-037 The bench SHALL cover: iter_num=2, samples 0x006, 0x006 -> votes[1]=votes[2]=2, winner=1 (tie, lowest index).
REQ-038 The bench SHALL cover: COUNT_W=3, iter_num=10, sample 0x001 every iteration -> votes[0]=7 (saturated), iter_count=10.
REQ-039 The bench SHALL cover: iter_num=0 -> out_valid within 2 cycles, all votes 0, layer_restart never pulses.
REQ-040 The bench SHALL cover: reset asserted in WAIT after 2 iterations, then out_ready held low in DONE -> outputs cleared and in_ready=1; out_valid held with stable winner for 5 cycles.
